ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter, the outbound counterpart of the mouse packet receiver. It sends one command byte to the mouse, e.g. 0xF4 "enable data reporting" or 0xFF "reset". It drives the open-drain PS/2 clock and data lines through low-enable outputs, and it checks the device's line-level acknowledge bit. It sits between the mouse init sequencer and the board's PS/2 pins, and shares those pins with the receiver.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its receiver counterpart.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_CLK,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [1:0] ERR_NONE         = 2'b00;
    localparam logic [1:0] ERR_NO_CLK       = 2'b01;
    localparam logic [1:0] ERR_XFER_TIMEOUT = 2'b10;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_DEFAULTS = 8'hF6;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    localparam int unsigned FRAME_W = 10;

    // Outbound frame, shifted out LSB first: data, odd parity, stop.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line with a registered falling-edge pulse.
module ps2_line_sync (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fe
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset to 1 so an idle bus never looks like an edge.
    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
            fe   <= 1'b0;
        end else begin
            meta <= line_in;
            sync <= meta;
            prev <= sync;
            fe   <= prev & ~sync;
        end
    end

    assign level = sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10_000,
    parameter int unsigned START_TIMEOUT  = 1_500_000,
    parameter int unsigned XFER_TIMEOUT   = 200_000
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned MAX_TO  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [3:0]       LAST_SEND  = 4'd9;

    ps2_tx_state_e        state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [3:0]           edge_cnt, edge_n;
    logic [FRAME_W-1:0]   shift, shift_n;
    logic                 clk_oe_n, data_oe_n, done_n, err_n, ack_n;
    logic [1:0]           code_n;
    logic                 present, abort;
    logic [1:0]           abort_code;

    logic clk_level, clk_fe, data_level, data_fe_unused;

    ps2_line_sync u_clk_sync (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .line_in      (ps2_clk_in),
        .level        (clk_level),
        .fe           (clk_fe)
    );

    ps2_line_sync u_data_sync (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .line_in      (ps2_data_in),
        .level        (data_level),
        .fe           (data_fe_unused)
    );

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            edge_cnt    <= '0;
            shift       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            edge_cnt    <= edge_n;
            shift       <= shift_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_ready    <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
            done        <= done_n;
            ack_ok      <= ack_n;
            err         <= err_n;
            err_code    <= code_n;
        end
    end

    // Timeouts are tested before edges so an expiring counter always wins.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        edge_n     = edge_cnt;
        shift_n    = shift;
        clk_oe_n   = 1'b0;
        data_oe_n  = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        ack_n      = ack_ok;
        code_n     = err_code;
        present    = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_n = INHIBIT;
                    shift_n = build_frame(tx_data);
                    cnt_n   = '0;
                    edge_n  = '0;
                    ack_n   = 1'b0;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_n = RTS;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RTS: begin
                state_n = WAIT_CLK;
                cnt_n   = '0;
            end
            WAIT_CLK: begin
                if (cnt == START_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_NO_CLK;
                end else if (clk_fe) begin
                    state_n = SEND;
                    present = 1'b1;
                    edge_n  = 4'd1;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SEND: begin
                if (cnt == XFER_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_XFER_TIMEOUT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (clk_fe) begin
                        present = 1'b1;
                        edge_n  = edge_cnt + 4'd1;
                        if (edge_cnt == LAST_SEND) begin
                            state_n = ACK;
                        end
                    end
                end
            end
            ACK: begin
                if (cnt == XFER_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_XFER_TIMEOUT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (clk_fe) begin
                        ack_n   = ~data_level;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (cnt == XFER_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_XFER_TIMEOUT;
                end else if (clk_level && data_level) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (abort) begin
            state_n = IDLE;
            err_n   = 1'b1;
            code_n  = abort_code;
            shift_n = '0;
            present = 1'b0;
        end

        if (present) begin
            shift_n = shift >> 1;
        end

        // Line drive follows the state being entered so the pins change with it.
        case (state_n)
            INHIBIT: clk_oe_n = 1'b1;
            RTS: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b1;
            end
            WAIT_CLK: data_oe_n = 1'b1;
            SEND, ACK: data_oe_n = present ? ~shift[0] : ps2_data_oe;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural open-drain PS/2 device.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 50;
    localparam int unsigned ST   = 2000;
    localparam int unsigned XT   = 20000;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_ok, err;
    logic [1:0] err_code;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    always #5 clk = ~clk;

    // Wired-AND bus with pull-ups.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .XFER_TIMEOUT   (XT)
    ) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clk_oe   (ps2_clk_oe),
        .ps2_data_oe  (ps2_data_oe),
        .busy         (busy),
        .done         (done),
        .ack_ok       (ack_ok),
        .err          (err),
        .err_code     (err_code)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct packed {
        logic [9:0] frame;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];

    int          r_clk_hi, r_rts_hi, r_pulses;
    logic        r_done, r_err, r_ack, r_ready_after, r_timeout;
    logic [1:0]  r_code, r_oe;
    logic [9:0]  r_cap;
    logic [3:0]  r_rst_snap;
    int unsigned t_fall, t_pin, t_evt;
    bit          rst_fired;

    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    // One command: host side issues and monitors, device side clocks n_edges and may reset the DUT.
    task automatic xfer(input logic [7:0] d, input int n_edges, input bit give_ack, input int rst_edge);
        r_clk_hi = 0; r_rts_hi = 0; r_pulses = 0;
        r_done = 0; r_err = 0; r_ack = 0; r_ready_after = 0; r_timeout = 0;
        r_code = 0; r_oe = 0; r_cap = '0; r_rst_snap = '0;
        t_fall = 0; t_pin = 0; t_evt = 0; rst_fired = 0;
        if (n_edges == 11) exp_q.push_back('{frame: model_frame(d), ack: give_ack});
        fork
            begin : host
                int n;
                @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = d;
                @(negedge clk);
                tx_valid = 1'b0;
                n = 0;
                while (ps2_clk_oe === 1'b1 && n < 1000) begin
                    r_clk_hi++;
                    if (ps2_data_oe === 1'b1) r_rts_hi++;
                    if (r_clk_hi == 10) begin
                        tx_valid = 1'b1;
                        tx_data  = ~d;
                    end
                    if (r_clk_hi == 13) tx_valid = 1'b0;
                    @(negedge clk);
                    n++;
                end
                t_fall = cyc_cnt;
                n = 0;
                while (!(done === 1'b1 || err === 1'b1) && !rst_fired && n < 30000) begin
                    @(negedge clk);
                    n++;
                end
                if (rst_fired) begin
                    repeat (200) begin
                        @(negedge clk);
                        if (done === 1'b1 || err === 1'b1) r_pulses++;
                    end
                end else if (n >= 30000) begin
                    r_timeout = 1'b1;
                end else begin
                    t_evt  = cyc_cnt;
                    r_done = done;
                    r_err  = err;
                    r_ack  = ack_ok;
                    r_code = err_code;
                    r_oe   = {ps2_clk_oe, ps2_data_oe};
                    @(negedge clk);
                    r_ready_after = tx_ready;
                end
            end
            begin : device
                int n;
                if (n_edges > 0) begin
                    n = 0;
                    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 1000) begin
                        @(negedge clk);
                        n++;
                    end
                    repeat (10) @(negedge clk);
                    for (int i = 1; i <= n_edges; i++) begin
                        dev_clk = 1'b0;
                        if (i == 1) t_pin = cyc_cnt;
                        if (i == rst_edge) begin
                            repeat (6) @(negedge clk);
                            reset = 1'b0;
                            @(negedge clk);
                            r_rst_snap = {ps2_clk_oe, ps2_data_oe, busy, tx_ready};
                            reset     = 1'b1;
                            dev_clk   = 1'b1;
                            rst_fired = 1'b1;
                            break;
                        end
                        repeat (HALF) @(negedge clk);
                        dev_clk = 1'b1;
                        if (i <= 10) r_cap[i-1] = ps2_data_in;
                        if (i == 10 && give_ack) dev_data = 1'b0;
                        repeat (HALF) @(negedge clk);
                        if (i == 11) dev_data = 1'b1;
                    end
                end
            end
        join
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, busy, done, err, ack_ok, err_code} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_status got=%b exp=%b", {tx_ready, busy, done, err, ack_ok, err_code}, 7'b1000000);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL reset_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=10", {tx_ready, busy});
        end
    endtask

    task automatic test_enable_ack();
        exp_t e;
        xfer(CMD_ENABLE, 11, 1'b1, 0);
        checks++;
        if (r_timeout !== 1'b0) begin errors++; $display("FAIL enable_timeout got=%b exp=0", r_timeout); end
        checks++;
        if (r_clk_hi !== int'(INH + 1)) begin errors++; $display("FAIL enable_clk_oe_len got=%0d exp=%0d", r_clk_hi, INH + 1); end
        checks++;
        if (r_rts_hi !== 1) begin errors++; $display("FAIL enable_rts_len got=%0d exp=1", r_rts_hi); end
        checks++;
        if (r_cap !== 10'b1_0_1111_0100) begin errors++; $display("FAIL enable_bits got=%b exp=%b", r_cap, 10'b1_0_1111_0100); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL enable_scoreboard got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            if (r_cap !== e.frame) begin errors++; $display("FAIL enable_frame got=%b exp=%b", r_cap, e.frame); end
            checks++;
            if (r_ack !== e.ack) begin errors++; $display("FAIL enable_ack_ok got=%b exp=%b", r_ack, e.ack); end
        end
        checks++;
        if ({r_done, r_err} !== 2'b10) begin errors++; $display("FAIL enable_done got=%b exp=10", {r_done, r_err}); end
        checks++;
        if (r_ready_after !== 1'b1) begin errors++; $display("FAIL enable_ready_after got=%b exp=1", r_ready_after); end
    endtask

    task automatic test_parity();
        logic [7:0] cmds [2];
        exp_t e;
        cmds[0] = 8'h00;
        cmds[1] = CMD_RESET;
        for (int k = 0; k < 2; k++) begin
            xfer(cmds[k], 11, 1'b1, 0);
            checks++;
            if (r_cap[8] !== 1'b1) begin errors++; $display("FAIL parity_%h got=%b exp=1", cmds[k], r_cap[8]); end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL parity_scoreboard got=empty exp=entry");
            end else begin
                e = exp_q.pop_front();
                if ({r_cap, r_done, r_ack} !== {e.frame, 1'b1, e.ack}) begin
                    errors++;
                    $display("FAIL parity_frame_%h got=%b exp=%b", cmds[k], {r_cap, r_done, r_ack}, {e.frame, 1'b1, e.ack});
                end
            end
        end
    endtask

    task automatic test_nack();
        exp_t e;
        xfer(CMD_DEFAULTS, 11, 1'b0, 0);
        checks++;
        if ({r_done, r_err} !== 2'b10) begin errors++; $display("FAIL nack_done got=%b exp=10", {r_done, r_err}); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL nack_scoreboard got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            if ({r_cap, r_ack} !== {e.frame, e.ack}) begin
                errors++;
                $display("FAIL nack_result got=%b exp=%b", {r_cap, r_ack}, {e.frame, e.ack});
            end
        end
    endtask

    task automatic test_no_clock();
        xfer(CMD_ENABLE, 0, 1'b0, 0);
        checks++;
        if ({r_done, r_err, r_code} !== {2'b01, ERR_NO_CLK}) begin
            errors++;
            $display("FAIL noclk_err got=%b exp=%b", {r_done, r_err, r_code}, {2'b01, ERR_NO_CLK});
        end
        checks++;
        if (t_evt - t_fall !== ST) begin errors++; $display("FAIL noclk_latency got=%0d exp=%0d", t_evt - t_fall, ST); end
        checks++;
        if (r_oe !== 2'b00) begin errors++; $display("FAIL noclk_oe got=%b exp=00", r_oe); end
    endtask

    // Pin fall reaches the FSM three cycles later, then the transfer timeout runs.
    task automatic test_stall();
        xfer(CMD_RESET, 5, 1'b0, 0);
        checks++;
        if ({r_done, r_err, r_code} !== {2'b01, ERR_XFER_TIMEOUT}) begin
            errors++;
            $display("FAIL stall_err got=%b exp=%b", {r_done, r_err, r_code}, {2'b01, ERR_XFER_TIMEOUT});
        end
        checks++;
        if (t_evt - t_pin !== XT + 3) begin errors++; $display("FAIL stall_latency got=%0d exp=%0d", t_evt - t_pin, XT + 3); end
        checks++;
        if (r_oe !== 2'b00) begin errors++; $display("FAIL stall_oe got=%b exp=00", r_oe); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        xfer(CMD_ENABLE, 10, 1'b1, 4);
        checks++;
        if ({rst_fired, r_rst_snap} !== 5'b1_0001) begin
            errors++;
            $display("FAIL midrst_state got=%b exp=10001", {rst_fired, r_rst_snap});
        end
        checks++;
        if (r_pulses !== 0) begin errors++; $display("FAIL midrst_pulses got=%0d exp=0", r_pulses); end
        xfer(CMD_RESET, 11, 1'b1, 0);
        checks++;
        if ({r_timeout, r_done, r_err, r_ready_after} !== 4'b0101) begin
            errors++;
            $display("FAIL after_rst_done got=%b exp=0101", {r_timeout, r_done, r_err, r_ready_after});
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL after_rst_scoreboard got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            if ({r_cap, r_ack} !== {e.frame, e.ack}) begin
                errors++;
                $display("FAIL after_rst_result got=%b exp=%b", {r_cap, r_ack}, {e.frame, e.ack});
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_enable_ack();
        test_parity();
        test_nack();
        test_no_clock();
        test_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
